// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz raster constants shared by the timing generator and overlay controllers.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Counter width used for hCount / vCount and every raster comparison
  localparam int CNT_W = 10;

  // Board clocks per pixel (100 MHz board clock -> 25 MHz pixel rate)
  localparam int DEF_CLK_DIV = 4;

  // Horizontal timing, in pixels
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_ACT_START = 144;
  localparam int DEF_H_ACT_END   = 784;

  // Vertical timing, in lines
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_ACT_START = 35;
  localparam int DEF_V_ACT_END   = 515;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-enable divider: pulses pix_tick on the last board clock of every CLK_DIV-clock pixel.
// Latency: first pix_tick CLK_DIV-1 clocks after reset release, then every CLK_DIV clocks.
// Backpressure: none, free-running.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Free-running modulo-CLK_DIV counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign pix_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus sync, visible-window and frame-start decodes.
// Latency: decodes are combinational from the registered counters; counters step on pix_tick.
// Backpressure: none, free-running. Optional frame counter under VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT_END   = DEF_H_ACT_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_ACT_START = DEF_V_ACT_START,
  parameter int V_ACT_END   = DEF_V_ACT_END
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic             pix_tick,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic h_last;
  logic v_last;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  assign h_last = (hCount == H_LAST);
  assign v_last = (vCount == V_LAST);

  // Raster counters: step once per pixel, line wrap carries into the line counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        hCount <= '0;
        if (v_last) begin
          vCount <= '0;
        end else begin
          vCount <= vCount + CNT_W'(1);
        end
      end else begin
        hCount <= hCount + CNT_W'(1);
      end
    end
  end

  // Sync and visible-window decodes; all-zero counters decode to all-zero outputs
  always_comb begin
    hSync  = !(hCount < CNT_W'(H_SYNC));
    vSync  = !(vCount < CNT_W'(V_SYNC));
    bright = (hCount >= CNT_W'(H_ACT_START)) && (hCount < CNT_W'(H_ACT_END)) &&
             (vCount >= CNT_W'(V_ACT_START)) && (vCount < CNT_W'(V_ACT_END));
  end

  assign frame_start = pix_tick && h_last && v_last;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter for blink/animation, wraps naturally at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
